shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle controller for the 32-bit shift datapath. It accepts one shift
//   command (operand, amount, op) and resolves it one binary stage per cycle
//   (1, 2, 4, 8, 16), reusing a single registered stage.
//   Sits beside the ALU as a low-area alternative to the 5-level mux shifter.
//   Reports completion with a one-cycle done pulse.
// PARAMETERS
//   WIDTH    32  datapath width in bits
//   SHAMT_W  5   shift-amount width; equals the number of stages (log2 WIDTH)
// PORTS
//   clk    in   1        rising-edge clock
//   reset  in   1        asynchronous, active-high reset
//   start  in   1        command valid; sampled only while busy=0
//   op     in   2        00=SLL, 01=SRL, 10=SRA, 11=ROR (rotate right)
//   A      in   WIDTH    operand, captured when start is accepted
//   B      in   SHAMT_W  shift amount, captured when start is accepted
//   busy   out  1        high while a command is in flight
//   done   out  1        one-cycle pulse; R valid in that cycle
//   R      out  WIDTH    result; holds its value until the next accepted start
// BEHAVIOUR
//   One clock domain. Reset is asynchronous and active-high.
//   Reset values: state=IDLE, busy=0, done=0, R=0, stage counter k=0,
//     internal op/amount registers cleared.
//   FSM states: IDLE -> SHIFT -> DONE.
//   - IDLE: busy=0, done=0.
//       If start=1 at a rising edge: capture A into the work register,
//       capture B and op, set k=0, go to SHIFT.
//   - SHIFT: busy=1. Each edge applies stage k to the work register:
//       if amt[k]=1, shift by 2^k; otherwise hold.
//       k increments each edge. On the edge that processes k=SHAMT_W-1, go to DONE.
//   - DONE: busy=0, done=1 for exactly this one cycle.
//       R = final work register, visible in the DONE cycle.
//       If start=1 in DONE, accept it (back-to-back) and go to SHIFT.
//       Otherwise go to IDLE.
//   Latency: start sampled at edge E0. Stages execute at edges E1..E5.
//     done=1 in the cycle after E5. Fixed, independent of B (B=0 also takes 5 stages).
//   Throughput: one command per 6 cycles.
//   Stage semantics for shift by s = 2^k on work register W:
//     SLL: zero-fill from bit 0.
//     SRL: zero-fill from bit WIDTH-1.
//     SRA: fill with W[WIDTH-1]. The sign is stable across stages.
//     ROR: bits shifted out at bit 0 re-enter at bit WIDTH-1.
//   Shift amounts are modulo 2^SHAMT_W. There are no carry or overflow outputs.
//   Boundary and error cases:
//   - start while busy=1 (SHIFT): ignored. No capture, no error.
//   - A, B, op changing during SHIFT: no effect (captured copies are used).
//   - reset asserted mid-SHIFT or in DONE: immediate return to reset values.
//       R clears to 0. No done pulse.
//   - B=31, SRA of a negative operand: result is all ones.
//   - R does not change between done pulses. It is updated only in the DONE cycle.
// TESTING
//   1. SLL A=32'h0000_0001 B=4 -> done after 6 cycles, R=32'h0000_0010.
//      busy high for exactly 5 cycles.
//   2. SRA A=32'h8000_0000 B=31 -> R=32'hFFFF_FFFF.
//      SRL with the same inputs -> R=32'h0000_0001.
//   3. ROR A=32'h0000_0001 B=1 -> R=32'h8000_0000.
//      ROR A=32'h1234_5678 B=16 -> R=32'h5678_1234.
//   4. start pulsed again at cycle E2 with different A/B -> ignored.
//      First result is unchanged and only one done pulse appears.
//   5. start held high continuously -> back-to-back accept in each DONE cycle.
//      done every 6 cycles. Results match the scoreboard, B=0 case included.
//   6. reset asserted at E3 of a command -> busy=0, done=0, R=0 immediately.
//      A new command after reset completes normally.
//   All cases: compare against a reference model using >>>, >>, <<, and rotate,
//   over 10k random A/B/op values.

Source files
------------

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle shifter controller. A shift command (operand A, amount B,
//   op) is accepted while the block is not busy. It is resolved one binary
//   stage per clock (by 1, 2, 4, 8, 16 ...) through a single registered
//   work stage. Every command takes exactly SHAMT_W stage cycles, whatever
//   the amount. Completion is signalled by a one-cycle done pulse, and R is
//   valid in that cycle.
//
// Ports
//   clk    in   1        rising-edge clock
//   reset  in   1        asynchronous, active-high reset
//   start  in   1        command valid; only looked at while busy=0
//   op     in   2        00=SLL, 01=SRL, 10=SRA, 11=ROR
//   A      in   WIDTH    operand, captured on accept
//   B      in   SHAMT_W  shift amount, captured on accept
//   busy   out  1        high while a command is in flight
//   done   out  1        one-cycle completion pulse
//   R      out  WIDTH    result; changes only when done rises
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] B,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   R
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Stage index counter width; it counts 0 .. SHAMT_W-1.
  localparam int            KW     = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SHAMT_W - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic [1:0]         op_q, op_d;
  logic [KW-1:0]      k_q, k_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   r_q, r_d;

  logic [SHAMT_W-1:0] stage_amt_s;
  logic [WIDTH-1:0]   stage_out_s;

  // One shift of w by s positions for the given op. s is always a power of two.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0]   w,
    input logic [1:0]         o,
    input logic [SHAMT_W-1:0] s
  );
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   res;
    dbl = {w, w} >> s;  // rotate: the low half of the shifted double word
    case (o)
      OP_SLL:  res = w << s;
      OP_SRL:  res = w >> s;
      OP_SRA:  res = $signed(w) >>> s;
      OP_ROR:  res = dbl[WIDTH-1:0];
      default: res = w;
    endcase
    return res;
  endfunction

  // Datapath for the current stage: shift by 2^k when amount bit k is set.
  always_comb begin
    stage_amt_s = SHAMT_W'(1) << k_q;
    if (amt_q[k_q]) begin
      stage_out_s = shift_stage(work_q, op_q, stage_amt_s);
    end else begin
      stage_out_s = work_q;
    end
  end

  // Sequencer next-state logic for the IDLE -> SHIFT -> DONE flow.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    amt_d   = amt_q;
    op_d    = op_q;
    k_d     = k_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    r_d     = r_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE also accepts, so commands can run back to back.
        if (start) begin
          work_d  = A;
          amt_d   = B;
          op_d    = op;
          k_d     = {KW{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = stage_out_s;
        if (k_q == K_LAST) begin
          // R is loaded on this edge so it is valid during the done cycle.
          r_d     = stage_out_s;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d    = k_q + KW'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= {WIDTH{1'b0}};
      amt_q   <= {SHAMT_W{1'b0}};
      op_q    <= 2'b00;
      k_q     <= {KW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign R    = r_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//   Self-checking bench for shift_sequencer. It uses a table of directed
//   commands with constant expected results, a mid-command reset sequence,
//   and a back-to-back random stream checked against a plain-arithmetic
//   reference model.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [4:0]  B;
  logic        busy;
  logic        done;
  logic [31:0] R;

  int n_vec  = 0;
  int n_miss = 0;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] exp;
    int          glitch;  // cycle at which a stray start is pulsed (0 = none)
  } vec_t;

  // Reference model: the whole shift is computed in one step.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [4:0] b);
    logic [31:0] r;
    case (o)
      2'b00:   r = a << b;
      2'b01:   r = a >> b;
      2'b10:   r = $signed(a) >>> b;
      default: r = (a >> b) | (a << (32 - int'(b)));
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one command, watches busy/done, then confirms that R holds and
  // no extra done pulse appears.
  task automatic run_cmd(input logic [1:0] o, input logic [31:0] a, input logic [4:0] b,
                         input logic [31:0] exp, input int glitch, input string tag);
    int          cyc;
    int          busy_cnt;
    int          done_cyc;
    int          extra;
    logic [31:0] r_seen;
    logic        r_moved;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    cyc = 0; busy_cnt = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) done_cyc = cyc;
      else if (busy) busy_cnt++;
      // Stray inputs while in flight must have no effect.
      start = (cyc == glitch) ? 1'b1 : 1'b0;
      A = $urandom; B = 5'($urandom); op = 2'($urandom);
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(done_cyc), 32'd6);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, "_R"}, R, exp);
    r_seen = R; extra = 0; r_moved = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) extra++;
      if (R !== r_seen) r_moved = 1'b1;
    end
    check({tag, "_extra_done"}, 32'(extra), 32'd0);
    check({tag, "_R_hold"}, {31'd0, r_moved}, 32'd0);
  endtask

  // Streams n commands with start held high; each result is checked against
  // the model, and the spacing between done pulses must be 6 cycles.
  task automatic stream(input int n);
    logic [31:0] exp_q[$];
    logic [1:0]  o;
    logic [31:0] a;
    logic [4:0]  b;
    int cyc = 0, last = 0, issued = 0, got = 0;
    @(negedge clk);
    o = 2'($urandom); a = $urandom; b = 5'd0;
    op = o; A = a; B = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
    issued++;
    while (got < n && cyc < n * 6 + 20) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check("b2b_R", R, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx);
        check("b2b_gap", 32'(cyc - last), 32'd6);
        last = cyc;
        got++;
        if (issued < n) begin
          o = 2'($urandom); a = $urandom;
          b = (issued % 7 == 0) ? 5'd0 : 5'($urandom);
          op = o; A = a; B = b;
          exp_q.push_back(model(o, a, b));
          issued++;
        end else begin
          start = 1'b0;
        end
      end else begin
        A = $urandom; B = 5'($urandom); op = 2'($urandom);
      end
    end
    start = 1'b0;
    check("b2b_completed", 32'(got), 32'(n));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, 0};
    vecs[1] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0};
    vecs[2] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 0};
    vecs[3] = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 0};
    vecs[4] = '{2'b11, 32'h1234_5678, 5'd16, 32'h5678_1234, 0};
    vecs[5] = '{2'b00, 32'h0000_0003, 5'd6,  32'h0000_00C0, 2};
    vecs[6] = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0};
    vecs[7] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 0};
    vecs[8] = '{2'b10, 32'hF000_0000, 5'd5,  32'hFF80_0000, 0};
    vecs[9] = '{2'b11, 32'hA5A5_0F0F, 5'd4,  32'hFA5A_50F0, 0};

    reset = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 5'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_R", R, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].glitch,
              $sformatf("vec%0d", i));
    end

    // Reset right after edge E3 of a command: everything clears at once.
    @(negedge clk);
    op = 2'b00; A = 32'h0000_00FF; B = 5'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_R", R, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_no_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    run_cmd(2'b01, 32'hF000_000F, 5'd4, 32'h0F00_0000, 0, "after_reset");

    stream(12);
    stream(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
